// File: rtl/parking_sensor_gen_pkg.sv
// Shared definitions for the parking-lot gate sensor: FSM state encoding
// and the two-beam (a,b) patterns used by both the generator and the
// entry/exit detector.
package parking_sensor_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // Beam patterns packed as {a, b}; a is the outer beam, b the inner beam.
  localparam logic [1:0] AB_ENTRY_PH1 = 2'b10;
  localparam logic [1:0] AB_ENTRY_PH2 = 2'b11;
  localparam logic [1:0] AB_ENTRY_PH3 = 2'b01;
  localparam logic [1:0] AB_EXIT_PH1  = 2'b01;
  localparam logic [1:0] AB_EXIT_PH2  = 2'b11;
  localparam logic [1:0] AB_EXIT_PH3  = 2'b10;
  localparam logic [1:0] AB_CLEAR     = 2'b00;

  // Beam pattern shown while in state st for a car travelling in direction
  // dir (1 = entry, 0 = exit). Consecutive phases differ in one beam only.
  function automatic logic [1:0] ab_pattern(input state_t st, input logic dir);
    logic [1:0] ab;
    ab = AB_CLEAR;
    case (st)
      ST_PH1:  ab = dir ? AB_ENTRY_PH1 : AB_EXIT_PH1;
      ST_PH2:  ab = dir ? AB_ENTRY_PH2 : AB_EXIT_PH2;
      ST_PH3:  ab = dir ? AB_ENTRY_PH3 : AB_EXIT_PH3;
      default: ab = AB_CLEAR;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/parking_sensor_gen_phase_timer.sv
// Loadable down-counter that times one FSM phase. A load sets the count to
// (phase length - 1); it then counts down and holds at zero, and o_zero
// marks the final cycle of the phase.
module parking_sensor_gen_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/parking_sensor_gen.sv
// Transmit side of the parking-lot gate sensor. Each accepted request
// produces the three-phase a/b beam waveform of one car driving through the
// gate, followed by a quiet gap, and bumps the entry or exit tally.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_ready is high exactly while the FSM is idle,
// and req_dir is captured on that same edge only.
module parking_sensor_gen
  import parking_sensor_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_dir,
  output logic             req_ready,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_entries,
  output logic [CNT_W-1:0] sent_exits,
  output logic [2:0]       dbg_state
);

  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_dir;
  logic             r_a;
  logic             r_b;
  logic [CNT_W-1:0] r_sent_entries;
  logic [CNT_W-1:0] r_sent_exits;

  logic             w_accept;
  logic             w_load;
  logic [TW-1:0]    w_load_val;
  logic             w_zero;
  logic             w_dir_nxt;
  logic [1:0]       w_ab_nxt;
  logic             w_done;
  logic             w_count;

  parking_sensor_gen_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  assign w_accept = req_valid && (r_state == ST_IDLE);

  // Next-state, timer load and next beam pattern; the beams are registered
  // from the next state so they change on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = HOLD_LOAD;
    w_done      = 1'b0;
    w_count     = 1'b0;
    w_dir_nxt   = r_dir;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_PH1;
          w_load      = 1'b1;
          w_dir_nxt   = req_dir;
        end
      end
      ST_PH1: begin
        if (w_zero) begin
          w_state_nxt = ST_PH2;
          w_load      = 1'b1;
        end
      end
      ST_PH2: begin
        if (w_zero) begin
          w_state_nxt = ST_PH3;
          w_load      = 1'b1;
        end
      end
      ST_PH3: begin
        if (w_zero) begin
          w_state_nxt = ST_GAP;
          w_load      = 1'b1;
          w_load_val  = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (w_zero) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
          w_count     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_ab_nxt = ab_pattern(w_state_nxt, w_dir_nxt);
  end

  // State, captured direction and registered beam outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dir   <= w_dir_nxt;
      r_a     <= w_ab_nxt[1];
      r_b     <= w_ab_nxt[0];
    end
  end

  // Wrap-around tallies of completed cars, bumped on the edge leaving GAP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sent_entries <= '0;
      r_sent_exits   <= '0;
    end else if (w_count) begin
      if (r_dir) begin
        r_sent_entries <= r_sent_entries + CNT_W'(1);
      end else begin
        r_sent_exits   <= r_sent_exits + CNT_W'(1);
      end
    end
  end

  assign req_ready    = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign done         = w_done;
  assign a            = r_a;
  assign b            = r_b;
  assign sent_entries = r_sent_entries;
  assign sent_exits   = r_sent_exits;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_parking_sensor_gen.sv
// Bench for parking_sensor_gen: a cycle-position model of one car checked
// on every falling edge, directed scenarios with literal expectations, and a
// simple beam-sequence detector that counts cars seen on a/b.
module tb_parking_sensor_gen;
  import parking_sensor_gen_pkg::*;

  localparam int H     = 4;
  localparam int G     = 8;
  localparam int CNT_W = 4;
  localparam int CAR   = 3 * H + G;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_dir;
  logic             req_ready;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_entries;
  logic [CNT_W-1:0] sent_exits;
  logic [2:0]       dbg_state;

  int n_pass;
  int n_total;

  // Model state: m_t is the cycle position within the current car, -1 = idle.
  int m_t;
  int m_dir;
  int m_ent;
  int m_ext;

  // Beam-sequence detector fed from the DUT outputs.
  logic [1:0] det_seq[$];
  logic [1:0] det_prev;
  int         det_occ;

  parking_sensor_gen #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_dir      (req_dir),
    .req_ready    (req_ready),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .sent_entries (sent_entries),
    .sent_exits   (sent_exits),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Expected {a,b} for a car at position t in direction dir.
  function automatic int exp_ab(input int t, input int dir);
    int ph;
    if (t < 0 || t >= 3 * H) return 0;
    ph = t / H;
    if (dir != 0) return (ph == 0) ? 2 : (ph == 1) ? 3 : 1;
    else          return (ph == 0) ? 1 : (ph == 1) ? 3 : 2;
  endfunction

  // ---------------- model + per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset) begin
      m_t = -1; m_ent = 0; m_ext = 0;
    end
    chk("ab",        int'({a, b}),        exp_ab(m_t, m_dir));
    chk("busy",      int'(busy),          (m_t >= 0) ? 1 : 0);
    chk("req_ready", int'(req_ready),     (m_t < 0) ? 1 : 0);
    chk("done",      int'(done),          (m_t == CAR - 1) ? 1 : 0);
    chk("entries",   int'(sent_entries),  m_ent);
    chk("exits",     int'(sent_exits),    m_ext);
    chk("dbg_idle",  int'(dbg_state == ST_IDLE), (m_t < 0) ? 1 : 0);
    if (reset) begin
      if (m_t < 0) begin
        if (req_valid) begin
          m_t = 0; m_dir = int'(req_dir);
        end
      end else if (m_t == CAR - 1) begin
        if (m_dir != 0) m_ent = (m_ent + 1) % (1 << CNT_W);
        else            m_ext = (m_ext + 1) % (1 << CNT_W);
        m_t = -1;
      end else begin
        m_t = m_t + 1;
      end
    end
  end

  // ---------------- detector on a/b ----------------
  always @(negedge clk) begin
    if (!reset) begin
      det_seq.delete();
      det_prev = 2'b00;
    end else if ({a, b} != det_prev) begin
      if ({a, b} == 2'b00) begin
        if (det_seq.size() == 3) begin
          if (det_seq[0] == 2'b10 && det_seq[1] == 2'b11 && det_seq[2] == 2'b01) det_occ++;
          if (det_seq[0] == 2'b01 && det_seq[1] == 2'b11 && det_seq[2] == 2'b10) det_occ--;
        end
        det_seq.delete();
      end else begin
        det_seq.push_back({a, b});
      end
      det_prev = {a, b};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; req_dir = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Present one request so it is accepted at the next edge (edge 0), then
  // drop req_valid just after that edge.
  task automatic send_one(input logic dir);
    @(posedge clk); #1;
    req_valid = 1'b1; req_dir = dir;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 3 * CAR);
    chk("done_timeout", int'(done), 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!req_ready && k < 3 * CAR) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", int'(req_ready), 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    n_pass = 0; n_total = 0;
    m_t = -1; m_dir = 0; m_ent = 0; m_ext = 0;
    det_occ = 0; det_prev = 2'b00;
    reset = 1'b0; req_valid = 1'b0; req_dir = 1'b0;
    #1;
    chk("rst_ab",    int'({a, b}), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy",  int'(busy), 0);
    do_reset();

    // Entry car: literal cycle positions after acceptance at edge 0.
    send_one(1'b1);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0)  chk("ent_c0_ab",  int'({a, b}), 2);
      if (k == 3)  chk("ent_c3_ab",  int'({a, b}), 2);
      if (k == 4)  chk("ent_c4_ab",  int'({a, b}), 3);
      if (k == 8)  chk("ent_c8_ab",  int'({a, b}), 1);
      if (k == 12) chk("ent_c12_ab", int'({a, b}), 0);
      if (k == 18) chk("ent_c18_done", int'(done), 0);
      if (k == 19) chk("ent_c19_done", int'(done), 1);
      if (k == 19) chk("ent_c19_cnt",  int'(sent_entries), 0);
      if (k == 20) chk("ent_c20_ready", int'(req_ready), 1);
      if (k == 20) chk("ent_c20_cnt",   int'(sent_entries), 1);
    end

    // Exit car.
    send_one(1'b0);
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0)  chk("ext_c0_ab",  int'({a, b}), 1);
      if (k == 4)  chk("ext_c4_ab",  int'({a, b}), 3);
      if (k == 8)  chk("ext_c8_ab",  int'({a, b}), 2);
      if (k == 12) chk("ext_c12_ab", int'({a, b}), 0);
      if (k == 20) chk("ext_c20_exits",   int'(sent_exits), 1);
      if (k == 20) chk("ext_c20_entries", int'(sent_entries), 1);
    end

    // Back-to-back with req_valid held high, direction 1,0,1.
    do_reset();
    @(posedge clk); #1;
    req_valid = 1'b1; req_dir = 1'b1;
    wait_done();
    @(posedge clk); #1 req_dir = 1'b0;
    wait_done();
    @(posedge clk); #1 req_dir = 1'b1;
    wait_done();
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_entries", int'(sent_entries), 2);
    chk("b2b_exits",   int'(sent_exits), 1);

    // Reset pulled mid-waveform (cycle 6 of an entry).
    send_one(1'b1);
    repeat (6) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_ab",      int'({a, b}), 0);
    chk("midrst_busy",    int'(busy), 0);
    chk("midrst_entries", int'(sent_entries), 0);
    chk("midrst_exits",   int'(sent_exits), 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", int'(req_ready), 1);

    // 17 back-to-back entries: the tally wraps 15 -> 0 -> 1.
    @(posedge clk); #1;
    req_valid = 1'b1; req_dir = 1'b1;
    for (int car = 1; car <= 17; car++) begin
      wait_done();
      @(negedge clk);
      if (car == 15) chk("wrap_15", int'(sent_entries), 15);
      if (car == 16) chk("wrap_16", int'(sent_entries), 0);
      if (car == 17) chk("wrap_17", int'(sent_entries), 1);
      if (car == 17) req_valid = 1'b0;
    end
    wait_idle();

    // Loop back into the detector: 3 entries then 1 exit.
    do_reset();
    det_occ = 0;
    for (int car = 0; car < 4; car++) begin
      send_one((car < 3) ? 1'b1 : 1'b0);
      wait_done();
      wait_idle();
    end
    repeat (2) @(negedge clk);
    chk("loop_occ",     det_occ, 2);
    chk("loop_entries", int'(sent_entries), 3);
    chk("loop_exits",   int'(sent_exits), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
